// File: rtl/jt900h_intc_pkg.sv
// Shared constants, state encoding and helpers for the jt900h interrupt controller.
package jt900h_intc_pkg;

   localparam int unsigned NSRC   = 8;
   localparam int unsigned LVL_W  = 3;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned CFG_AW = 4;
   localparam int unsigned DW     = 8;

   // Configuration address map: 0..NSRC-1 are per-source registers
   localparam logic [CFG_AW-1:0] CFG_ADDR_VBASE = 4'd8;

   // Per-source configuration/readback bit positions
   localparam int unsigned CFG_LVL_LSB  = 0;
   localparam int unsigned CFG_LVL_MSB  = 2;
   localparam int unsigned CFG_EDGE_BIT = 3;
   localparam int unsigned CFG_PEND_BIT = 7;

   typedef logic [LVL_W-1:0] lvl_t;
   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   // Vector low byte: base plus four bytes per source, wrapping at 256
   function automatic logic [DW-1:0] vec_addr(input logic [DW-1:0] vbase, input idx_t idx);
      return vbase + {3'b000, idx, 2'b00};
   endfunction

endpackage

// File: rtl/jt900h_intc_arb.sv
// Combinational priority encoder: highest level wins, lowest index breaks ties.
module jt900h_intc_arb
   import jt900h_intc_pkg::*;
(
   input  logic [NSRC-1:0]       pend_i,
   input  lvl_t [NSRC-1:0]       lvl_i,
   output logic                  valid_o,
   output idx_t                  idx_o,
   output lvl_t                  lvl_o
);

   logic v;
   idx_t ix;
   lvl_t lv;

   // Ascending scan with strict compare keeps the lowest index on ties
   always_comb begin
      v  = 1'b0;
      ix = '0;
      lv = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (pend_i[i] && (lvl_i[i] != '0) && (!v || (lvl_i[i] > lv))) begin
            v  = 1'b1;
            ix = IDX_W'(i);
            lv = lvl_i[i];
         end
      end
   end

   assign valid_o = v;
   assign idx_o   = ix;
   assign lvl_o   = lv;

endmodule

// File: rtl/jt900h_intc.sv
// Eight-source prioritised interrupt controller with vectored addresses.
module jt900h_intc
   import jt900h_intc_pkg::*;
#(
   parameter logic [7:0] VBASE_RST = 8'h00,
   parameter logic       INTA      = 1'b1
) (
   input  logic              rst,
   input  logic              clk,
   input  logic              cen,
   input  logic [NSRC-1:0]   src,
   input  logic              cfg_we,
   input  logic [CFG_AW-1:0] cfg_addr,
   input  logic [DW-1:0]     cfg_din,
   output logic [DW-1:0]     cfg_dout,
   output logic              irq,
   output logic [LVL_W-1:0]  intrq,
   input  logic              irq_ack,
   output logic              inta_en,
   output logic [DW-1:0]     int_addr
);

   lvl_t [NSRC-1:0] lvl_q, lvl_d;
   logic [NSRC-1:0] edge_q, edge_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] src_q, hist_q;
   logic [DW-1:0]   vbase_q, vbase_d;
   logic            ack_q;
   state_e          state_q;
   idx_t            cur_idx_q;
   lvl_t            cur_lvl_q;
   logic            irq_q;
   lvl_t            intrq_q;
   logic [DW-1:0]   int_addr_q;

   logic            win_valid;
   idx_t            win_idx;
   lvl_t            win_lvl;
   logic            ack_rise;
   logic            ack_take;
   logic            src_wr;
   idx_t            wr_idx;

   assign src_wr   = cfg_we && (cfg_addr < CFG_AW'(NSRC));
   assign wr_idx   = cfg_addr[IDX_W-1:0];
   assign ack_rise = irq_ack && !ack_q;
   assign ack_take = (state_q == ST_REQ) && win_valid && ack_rise;

   jt900h_intc_arb u_arb (
      .pend_i  (pend_q),
      .lvl_i   (lvl_q),
      .valid_o (win_valid),
      .idx_o   (win_idx),
      .lvl_o   (win_lvl)
   );

   // Configuration register next values
   always_comb begin
      lvl_d   = lvl_q;
      edge_d  = edge_q;
      vbase_d = vbase_q;
      if (cfg_we && (cfg_addr == CFG_ADDR_VBASE)) begin
         vbase_d = cfg_din;
      end else if (src_wr) begin
         lvl_d[wr_idx]  = cfg_din[CFG_LVL_MSB:CFG_LVL_LSB];
         edge_d[wr_idx] = cfg_din[CFG_EDGE_BIT];
      end
   end

   // Pending bits: edge mode latches until acked, level mode follows registered src
   always_comb begin
      pend_d = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (edge_q[i]) begin
            pend_d[i] = (pend_q[i] && !(ack_take && (cur_idx_q == IDX_W'(i))))
                      || (src_q[i] && !hist_q[i] && (lvl_q[i] != '0));
         end else begin
            pend_d[i] = src_q[i] && (lvl_q[i] != '0);
         end
         if (src_wr && (wr_idx == IDX_W'(i)) && (cfg_din[CFG_LVL_MSB:CFG_LVL_LSB] == '0)) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // Register readback; pending shown in bit 7 for sources
   always_comb begin
      cfg_dout = '0;
      if (cfg_addr == CFG_ADDR_VBASE) begin
         cfg_dout = vbase_q;
      end else if (cfg_addr < CFG_AW'(NSRC)) begin
         cfg_dout[CFG_PEND_BIT]             = pend_q[wr_idx];
         cfg_dout[CFG_EDGE_BIT]             = edge_q[wr_idx];
         cfg_dout[CFG_LVL_MSB:CFG_LVL_LSB]  = lvl_q[wr_idx];
      end
   end

   // State, configuration and request handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q      <= '0;
         edge_q     <= '0;
         pend_q     <= '0;
         src_q      <= '0;
         hist_q     <= '0;
         vbase_q    <= VBASE_RST;
         ack_q      <= 1'b0;
         state_q    <= ST_IDLE;
         cur_idx_q  <= '0;
         cur_lvl_q  <= '0;
         irq_q      <= 1'b0;
         intrq_q    <= '0;
         int_addr_q <= VBASE_RST;
      end else if (cen) begin
         lvl_q   <= lvl_d;
         edge_q  <= edge_d;
         pend_q  <= pend_d;
         src_q   <= src;
         hist_q  <= src_q;
         vbase_q <= vbase_d;
         ack_q   <= irq_ack;
         case (state_q)
            ST_IDLE: begin
               if (win_valid) begin
                  state_q    <= ST_REQ;
                  cur_idx_q  <= win_idx;
                  cur_lvl_q  <= win_lvl;
                  irq_q      <= 1'b1;
                  intrq_q    <= win_lvl;
                  int_addr_q <= vec_addr(vbase_d, win_idx);
               end else begin
                  irq_q      <= 1'b0;
                  intrq_q    <= '0;
                  int_addr_q <= vec_addr(vbase_d, cur_idx_q);
               end
            end
            ST_REQ: begin
               if (!win_valid) begin
                  state_q    <= ST_IDLE;
                  irq_q      <= 1'b0;
                  intrq_q    <= '0;
                  int_addr_q <= vec_addr(vbase_d, cur_idx_q);
               end else if (ack_rise) begin
                  state_q    <= ST_ACK;
                  irq_q      <= 1'b0;
               end else if (win_lvl > cur_lvl_q) begin
                  cur_idx_q  <= win_idx;
                  cur_lvl_q  <= win_lvl;
                  intrq_q    <= win_lvl;
                  int_addr_q <= vec_addr(vbase_d, win_idx);
               end else begin
                  int_addr_q <= vec_addr(vbase_d, cur_idx_q);
               end
            end
            ST_ACK: begin
               if (!irq_ack) begin
                  state_q    <= ST_IDLE;
                  intrq_q    <= '0;
                  int_addr_q <= vec_addr(vbase_d, cur_idx_q);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               irq_q   <= 1'b0;
               intrq_q <= '0;
            end
         endcase
      end
   end

   assign irq      = irq_q;
   assign intrq    = intrq_q;
   assign int_addr = int_addr_q;
   assign inta_en  = INTA;

endmodule

// File: tb/tb_jt900h_intc.sv
// Directed vector bench for the jt900h interrupt controller.
module tb_jt900h_intc;

   logic       clk = 1'b0;
   logic       rst, cen, cfg_we, irq_ack;
   logic [7:0] src, cfg_din;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_dout, int_addr;
   logic       irq, inta_en;
   logic [2:0] intrq;

   int errs   = 0;
   int checks = 0;

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] din;
      logic [7:0] src;
      logic       ack;
      logic       irq;
      logic [2:0] intrq;
      logic [7:0] iaddr;
      logic [7:0] dout;
   } vec_t;

   localparam int NVEC = 26;
   vec_t tbl[NVEC];

   jt900h_intc #(.VBASE_RST(8'h10), .INTA(1'b1)) dut (
      .rst      (rst),
      .clk      (clk),
      .cen      (cen),
      .src      (src),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_din  (cfg_din),
      .cfg_dout (cfg_dout),
      .irq      (irq),
      .intrq    (intrq),
      .irq_ack  (irq_ack),
      .inta_en  (inta_en),
      .int_addr (int_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
      cfg_addr = a;
      #1;
      chk(name, 32'(cfg_dout), 32'(exp));
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      //             we    addr   din    src    ack   irq  intrq iaddr  dout
      tbl[0]  = '{1'b1, 4'd3, 8'h0D, 8'h00, 1'b0, 1'b0, 3'd0, 8'h10, 8'h0D};
      tbl[1]  = '{1'b1, 4'd8, 8'h40, 8'h00, 1'b0, 1'b0, 3'd0, 8'h40, 8'h40};
      tbl[2]  = '{1'b0, 4'd3, 8'h00, 8'h08, 1'b0, 1'b0, 3'd0, 8'h40, 8'h0D};
      tbl[3]  = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h40, 8'h8D};
      tbl[4]  = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h4C, 8'h8D};
      tbl[5]  = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h4C, 8'h0D};
      tbl[6]  = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h4C, 8'h0D};
      tbl[7]  = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h4C, 8'h0D};
      tbl[8]  = '{1'b1, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h4C, 8'h00};
      tbl[9]  = '{1'b1, 4'd1, 8'h0C, 8'h00, 1'b0, 1'b0, 3'd0, 8'h4C, 8'h0C};
      tbl[10] = '{1'b1, 4'd6, 8'h0C, 8'h00, 1'b0, 1'b0, 3'd0, 8'h4C, 8'h0C};
      tbl[11] = '{1'b0, 4'd6, 8'h00, 8'h42, 1'b0, 1'b0, 3'd0, 8'h4C, 8'h0C};
      tbl[12] = '{1'b0, 4'd6, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h4C, 8'h8C};
      tbl[13] = '{1'b0, 4'd6, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h44, 8'h8C};
      tbl[14] = '{1'b0, 4'd6, 8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 8'h44, 8'h8C};
      tbl[15] = '{1'b0, 4'd6, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h44, 8'h8C};
      tbl[16] = '{1'b0, 4'd6, 8'h00, 8'h00, 1'b0, 1'b1, 3'd4, 8'h58, 8'h8C};
      tbl[17] = '{1'b0, 4'd6, 8'h00, 8'h00, 1'b1, 1'b0, 3'd4, 8'h58, 8'h0C};
      tbl[18] = '{1'b0, 4'd6, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h58, 8'h0C};
      tbl[19] = '{1'b1, 4'd8, 8'hF8, 8'h00, 1'b0, 1'b0, 3'd0, 8'h10, 8'hF8};
      tbl[20] = '{1'b1, 4'd7, 8'h0B, 8'h00, 1'b0, 1'b0, 3'd0, 8'h10, 8'h0B};
      tbl[21] = '{1'b0, 4'd7, 8'h00, 8'h80, 1'b0, 1'b0, 3'd0, 8'h10, 8'h0B};
      tbl[22] = '{1'b0, 4'd7, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h10, 8'h8B};
      tbl[23] = '{1'b0, 4'd7, 8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h14, 8'h8B};
      tbl[24] = '{1'b0, 4'd7, 8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 8'h14, 8'h0B};
      tbl[25] = '{1'b0, 4'd7, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h14, 8'h0B};

      // Reset while cen is low
      rst = 1'b1; cen = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd8; cfg_din = 8'h00;
      src = 8'h00; irq_ack = 1'b0;
      step(); step();
      chk("rst irq", 32'(irq), 32'd0);
      chk("rst intrq", 32'(intrq), 32'd0);
      chk("rst int_addr", 32'(int_addr), 32'h10);
      chk("inta_en", 32'(inta_en), 32'd1);
      rd(4'd8, 8'h10, "rst vbase");
      rd(4'd3, 8'h00, "rst src3 cfg");
      rst = 1'b0; cen = 1'b1;
      wr(4'd12, 8'hFF);
      rd(4'd12, 8'h00, "addr12 readback");
      rd(4'd8, 8'h10, "vbase after addr12 write");

      // Table: single edge source, tie-break, vector wrap
      for (int k = 0; k < NVEC; k++) begin
         cfg_we = tbl[k].we; cfg_addr = tbl[k].addr; cfg_din = tbl[k].din;
         src = tbl[k].src; irq_ack = tbl[k].ack;
         step();
         chk($sformatf("v%0d irq", k), 32'(irq), 32'(tbl[k].irq));
         chk($sformatf("v%0d intrq", k), 32'(intrq), 32'(tbl[k].intrq));
         chk($sformatf("v%0d int_addr", k), 32'(int_addr), 32'(tbl[k].iaddr));
         chk($sformatf("v%0d cfg_dout", k), 32'(cfg_dout), 32'(tbl[k].dout));
      end
      cfg_we = 1'b0; src = 8'h00; irq_ack = 1'b0;

      // Higher level pre-empts before ack; edge coinciding with ack clear survives
      wr(4'd2, 8'h0A);
      wr(4'd0, 8'h0E);
      src = 8'h04; step(); src = 8'h00; step(); step();
      chk("preempt base irq", 32'(irq), 32'd1);
      chk("preempt base intrq", 32'(intrq), 32'd2);
      chk("preempt base addr", 32'(int_addr), 32'h00);
      src = 8'h01; step(); src = 8'h00; step();
      chk("preempt not yet", 32'(intrq), 32'd2);
      step();
      chk("preempt intrq", 32'(intrq), 32'd6);
      chk("preempt addr", 32'(int_addr), 32'hF8);
      chk("preempt irq", 32'(irq), 32'd1);
      irq_ack = 1'b1; step();
      chk("preempt ack irq", 32'(irq), 32'd0);
      chk("preempt ack intrq", 32'(intrq), 32'd6);
      rd(4'd0, 8'h0E, "src0 cleared by ack");
      irq_ack = 1'b0; step(); step();
      chk("resume src2 irq", 32'(irq), 32'd1);
      chk("resume src2 intrq", 32'(intrq), 32'd2);
      src = 8'h04; step();
      src = 8'h00; irq_ack = 1'b1; step();
      chk("ack+edge irq", 32'(irq), 32'd0);
      rd(4'd2, 8'h8A, "ack+edge pending kept");
      irq_ack = 1'b0; step(); step();
      chk("re-request irq", 32'(irq), 32'd1);
      irq_ack = 1'b1; step(); irq_ack = 1'b0; step();
      rd(4'd2, 8'h0A, "src2 finally cleared");
      step();
      chk("idle after src2", 32'(irq), 32'd0);

      // Level mode follows src; level 0 write clears pending immediately
      wr(4'd5, 8'h01);
      src = 8'h20; step(); step();
      rd(4'd5, 8'h81, "level pending");
      step();
      chk("level irq", 32'(irq), 32'd1);
      chk("level intrq", 32'(intrq), 32'd1);
      chk("level addr", 32'(int_addr), 32'h0C);
      src = 8'h00; step(); step();
      chk("level pend drop", 32'(cfg_dout), 32'h01);
      step();
      chk("level drop irq", 32'(irq), 32'd0);
      chk("level drop intrq", 32'(intrq), 32'd0);
      src = 8'h20; step(); step();
      rd(4'd5, 8'h81, "level pend again");
      wr(4'd5, 8'h00);
      chk("lvl0 clears pending", 32'(cfg_dout), 32'h00);
      step();
      chk("disabled irq", 32'(irq), 32'd0);
      src = 8'h00; step();

      // cen low freezes everything; reset in ACK
      wr(4'd4, 8'h0F);
      cen = 1'b0;
      src = 8'h10; step(); step();
      src = 8'h00; step(); step();
      chk("cen low irq", 32'(irq), 32'd0);
      rd(4'd4, 8'h0F, "cen low no pending");
      cen = 1'b1; step(); step();
      chk("cen restore irq", 32'(irq), 32'd0);
      chk("cen restore pending", 32'(cfg_dout), 32'h0F);
      src = 8'h10; step(); src = 8'h00; step(); step();
      chk("src4 irq", 32'(irq), 32'd1);
      chk("src4 intrq", 32'(intrq), 32'd7);
      chk("src4 addr", 32'(int_addr), 32'h08);
      irq_ack = 1'b1; step();
      chk("src4 ack irq", 32'(irq), 32'd0);
      rst = 1'b1; cen = 1'b0; step();
      chk("rst in ack irq", 32'(irq), 32'd0);
      chk("rst in ack intrq", 32'(intrq), 32'd0);
      chk("rst in ack addr", 32'(int_addr), 32'h10);
      rd(4'd4, 8'h00, "rst in ack cfg4");
      rd(4'd8, 8'h10, "rst in ack vbase");
      rst = 1'b0; irq_ack = 1'b0; cen = 1'b1; step(); step();
      chk("post rst idle", 32'(irq), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/jt900h_intc.md
JT900H_INTC -- requirements
Module: jt900h_intc

Interface
REQ-001 SHALL have parameter VBASE_RST, default 8'h00: reset value of the vector base register.
REQ-002 SHALL have parameter INTA, default 1'b1: constant value driven on inta_en.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port cen  input  1  clock enable; no state changes when low.
REQ-006 SHALL have port src  input  8  interrupt sources, clk-synchronous, active-high.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-008 SHALL have port cfg_addr  input  4  0-7 source config; 8 vector base; 9-15 ignored.
REQ-009 SHALL have port cfg_din  input  8  write data; source config uses [2:0]=level, [3]=edge mode.
REQ-010 SHALL have port cfg_dout  output  8  combinational readback of the cfg_addr register; pending bit in [7] for sources; 0 for 9-15.
REQ-011 SHALL have port irq  output  1  request to CPU.
REQ-012 SHALL have port intrq  output  3  level of the current request.
REQ-013 SHALL have port irq_ack  input  1  CPU acknowledge level.
REQ-014 SHALL have port inta_en  output  1  equals INTA.
REQ-015 SHALL have port int_addr  output  8  vector low byte.

Function
REQ-016 Level 0 SHALL disable a source; writing level 0 SHALL clear its pending bit in the same write cycle.
REQ-017 Edge mode: pending SHALL set on the cycle after a 0->1 transition of src (previous-value register, sampled only when cen is high).
REQ-018 Level mode: pending SHALL equal registered src, never latched.
REQ-019 Arbitration SHALL pick the highest level among enabled pending sources; on a tie, the lowest index wins.
REQ-020 FSM SHALL have states IDLE, REQ, ACK.
REQ-021 IDLE: irq=0; any winner -> REQ, latching cur_idx and cur_lvl.
REQ-022 REQ: irq=1 and intrq=cur_lvl.
REQ-023 REQ: a winner with a strictly higher level SHALL replace cur_idx and cur_lvl.
REQ-024 REQ: no winner (source dropped or disabled) -> IDLE.
REQ-025 REQ: a rising edge of irq_ack -> ACK, and the cur_idx edge-mode pending bit SHALL be cleared.
REQ-026 ACK: irq=0; int_addr and intrq SHALL hold; on irq_ack low -> IDLE.
REQ-027 int_addr SHALL equal vbase + {cur_idx,2'b00}, modulo 256 (wraps).
REQ-028 A new edge on the same source in the same cycle as its ack clear SHALL leave pending set.
REQ-029 A configuration write during REQ or ACK SHALL take effect next cycle; cur_idx/cur_lvl SHALL NOT change in ACK.
REQ-030 Latency: src rising at edge n SHALL give pending at n+1 and irq at n+2, all with cen high.

Reset
REQ-031 On rst: all levels 0, edge bits 0, pending 0, src history 0, vbase=VBASE_RST, state IDLE.
REQ-032 On rst: irq=0, intrq=0, int_addr=VBASE_RST.
REQ-033 rst SHALL take effect regardless of cen.
REQ-034 rst mid-handshake SHALL return to IDLE with no pending bits.

Structure
REQ-035 A shared package SHALL hold the state encodings, NSRC=8, the cfg address constants, and the config bit positions.
REQ-036 A sub-module jt900h_intc_arb SHALL implement the purely combinational priority encoder (pending, levels -> valid, idx, lvl).

Verification
REQ-037 Source 3 at level 5, edge mode, vbase 8'h40; src[3] pulse -> irq=1 two cycles later with intrq=5 and int_addr=8'h4C.
REQ-038 Sources 1 and 6 both at level 4, pending together -> cur_idx=1; after ack, source 6 is served with int_addr=vbase+24.
REQ-039 In REQ serving level 2, source 0 at level 6 fires -> intrq changes to 6 before ack.
REQ-040 Level-mode source drops in REQ -> irq=0 next cycle, and no pending remains.
REQ-041 vbase=8'hF8 with source 7 -> int_addr=8'h14.
REQ-042 cen held low for 4 cycles during a src pulse -> no state change; rst asserted in ACK -> IDLE and all outputs at reset values.
